outer_product_engine: RTL

OUTER_PRODUCT_ENGINE -- requirements
Module: outer_product_engine

---
 rtl/outer_product_engine.sv | 133 +++++++++++++
 1 files changed

// File: rtl/outer_product_engine.sv
// Outer-product engine: loads two N-element vectors, then streams all N*N products
// A[i]*B[j] in row- or column-major order. Define OPE_SIGNED_EN for two's-complement operands.
module outer_product_engine #(
  parameter int N   = 16,
  parameter int A_W = 4,
  parameter int B_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [A_W-1:0]     in_a,
  input  logic [B_W-1:0]     in_b,
  input  logic               in_mode,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [A_W+B_W-1:0] out_matrix,
  output logic               busy
);

  localparam int IDX_W = $clog2(N);
  localparam int P_W   = A_W + B_W;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {IDLE, LOAD, STREAM} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] load_idx_q, load_idx_d;
  logic [IDX_W-1:0] i_q, i_d, j_q, j_d;
  logic             mode_q, mode_d;
  logic             wr_en;

  logic [IDX_W-1:0] fast_idx, slow_idx, fast_nxt, slow_nxt;

  logic [A_W-1:0] a_mem [N];
  logic [B_W-1:0] b_mem [N];

  // NOTE: the vector storage carries no reset; its contents are never visible
  // until a full load has overwritten every entry, so a reset would only cost area.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      a_mem[load_idx_q] <= in_a;
      b_mem[load_idx_q] <= in_b;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      load_idx_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
      mode_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_idx_q <= load_idx_d;
      i_q        <= i_d;
      j_q        <= j_d;
      mode_q     <= mode_d;
    end
  end

  // Mode 0 walks j fastest, mode 1 walks i fastest; map both onto fast/slow.
  always_comb begin
    fast_idx = mode_q ? i_q : j_q;
    slow_idx = mode_q ? j_q : i_q;
    fast_nxt = fast_idx + IDX_W'(1);
    slow_nxt = slow_idx;
    if (fast_idx == LAST) begin
      fast_nxt = '0;
      slow_nxt = (slow_idx == LAST) ? '0 : slow_idx + IDX_W'(1);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state_q;
    load_idx_d = load_idx_q;
    i_d        = i_q;
    j_d        = j_q;
    mode_d     = mode_q;
    wr_en      = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          wr_en      = 1'b1;
          mode_d     = in_mode;
          load_idx_d = IDX_W'(1);
          state_d    = LOAD;
        end
      end
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (load_idx_q == LAST) begin
            load_idx_d = '0;
            state_d    = STREAM;
          end else begin
            load_idx_d = load_idx_q + IDX_W'(1);
          end
        end
      end
      STREAM: begin
        if (out_ready) begin
          i_d = mode_q ? fast_nxt : slow_nxt;
          j_d = mode_q ? slow_nxt : fast_nxt;
          if (fast_idx == LAST && slow_idx == LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  logic [A_W-1:0] op_a;
  logic [B_W-1:0] op_b;
  logic [P_W-1:0] product;

  assign op_a = a_mem[i_q];
  assign op_b = b_mem[j_q];

`ifdef OPE_SIGNED_EN
  // Sign-extend to full width; the low P_W bits of the product are then sign-correct.
  assign product = {{B_W{op_a[A_W-1]}}, op_a} * {{A_W{op_b[B_W-1]}}, op_b};
`else
  assign product = {{B_W{1'b0}}, op_a} * {{A_W{1'b0}}, op_b};
`endif

  assign out_valid  = (state_q == STREAM);
  assign out_matrix = out_valid ? product : '0;
  assign busy       = (state_q != IDLE);

endmodule
